// File: rtl/remote_pkg.sv
// Shared remote-control frame definitions: field lengths, FSM encoding and key filter.
// Used by both the transmitter and the receiver so the two always agree on the frame.
package remote_pkg;

  localparam int CUSTOM_BITS = 16;
  localparam int KEY_BITS    = 8;
  localparam int MIN_GAP     = 4;   // receiver needs this many idle-high cycles to re-arm
  localparam int MAX_GAP     = 15;
  localparam int CNT_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_PAD    = 3'd2,
    ST_CUSTOM = 3'd3,
    ST_DATA   = 3'd4,
    ST_INV    = 3'd5,
    ST_GAP    = 3'd6
  } state_t;

  // Keys the receiver accepts: 0x00..0x1F minus the eight codes it reserves.
  function automatic logic key_is_valid(input logic [KEY_BITS-1:0] key);
    logic ok;
    ok = (key <= 8'h1F);
    case (key)
      8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h15, 8'h19, 8'h1C, 8'h1D: ok = 1'b0;
      default: ;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/remote_transmitter.sv
// Serialises one key into the receiver's one-bit-per-clock frame:
// START, PAD, custom code, key, inverted key, then an idle-high gap.
module remote_transmitter
  import remote_pkg::*;
#(
  parameter logic [CUSTOM_BITS-1:0] CUSTOM_CODE = 16'h0000,
  parameter int                     GAP_CYCLES  = 4,
  parameter bit                     CHECK_KEY   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send,
  input  logic [KEY_BITS-1:0] tecla,
  output logic                serial,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // Out-of-range gaps are pulled into the legal window rather than breaking the receiver.
  localparam int GAP_EFF = (GAP_CYCLES < MIN_GAP) ? MIN_GAP :
                           (GAP_CYCLES > MAX_GAP) ? MAX_GAP : GAP_CYCLES;

  localparam logic [CNT_W-1:0] CUSTOM_RELOAD = CNT_W'(CUSTOM_BITS - 1);
  localparam logic [CNT_W-1:0] KEY_RELOAD    = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD    = CNT_W'(GAP_EFF - 1);
  localparam int               PAD_ZEROS     = CUSTOM_BITS - KEY_BITS + 1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CUSTOM_BITS-1:0] shreg;
  logic [KEY_BITS-1:0]    key_q;
  logic [KEY_BITS-1:0]    key_inv;
  logic                   key_ok;
  logic                   at_rest;

  assign key_inv = ~key_q;

  // The last gap edge doubles as an accept point so back-to-back frames keep the exact gap.
  always_comb begin
    key_ok  = !CHECK_KEY || key_is_valid(tecla);
    at_rest = (state == ST_IDLE) || (state == ST_GAP && cnt == '0);
  end

  // NOTE: all state and outputs use non-blocking assignments; a later assignment in the
  // same block overrides an earlier one, which the accept logic below relies on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      key_q  <= '0;
      serial <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          serial <= 1'b1;
          busy   <= 1'b0;
        end
        ST_START: begin
          state  <= ST_PAD;
          serial <= 1'b1;
        end
        ST_PAD: begin
          state  <= ST_CUSTOM;
          cnt    <= CUSTOM_RELOAD;
          serial <= CUSTOM_CODE[CUSTOM_BITS-1];
          shreg  <= {CUSTOM_CODE[CUSTOM_BITS-2:0], 1'b0};
        end
        ST_CUSTOM: begin
          if (cnt == '0) begin
            state  <= ST_DATA;
            cnt    <= KEY_RELOAD;
            serial <= key_q[KEY_BITS-1];
            shreg  <= {key_q[KEY_BITS-2:0], {PAD_ZEROS{1'b0}}};
          end else begin
            cnt    <= cnt - 1'b1;
            serial <= shreg[CUSTOM_BITS-1];
            shreg  <= shreg << 1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            state  <= ST_INV;
            cnt    <= KEY_RELOAD;
            serial <= key_inv[KEY_BITS-1];
            shreg  <= {key_inv[KEY_BITS-2:0], {PAD_ZEROS{1'b0}}};
          end else begin
            cnt    <= cnt - 1'b1;
            serial <= shreg[CUSTOM_BITS-1];
            shreg  <= shreg << 1;
          end
        end
        ST_INV: begin
          if (cnt == '0) begin
            state  <= ST_GAP;
            cnt    <= GAP_RELOAD;
            serial <= 1'b1;
          end else begin
            cnt    <= cnt - 1'b1;
            serial <= shreg[CUSTOM_BITS-1];
            shreg  <= shreg << 1;
          end
        end
        ST_GAP: begin
          serial <= 1'b1;
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          serial <= 1'b1;
          busy   <= 1'b0;
        end
      endcase

      if (at_rest && send) begin
        if (key_ok) begin
          state  <= ST_START;
          key_q  <= tecla;
          serial <= 1'b0;
          busy   <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_remote_transmitter.sv
// Self-checking bench: a per-cycle line scoreboard for two transmitter configurations
// plus a frame decoder that stands in for the receiver on the first one.
module tb_remote_transmitter;

  localparam logic [15:0] CUSTOM = 16'hA55A;
  localparam int GAP_A = 4;
  localparam int GAP_B = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic send_a = 1'b0, send_b = 1'b0;
  logic [7:0] tecla_a = 8'h00, tecla_b = 8'h00;
  logic serial_a, busy_a, done_a, err_a;
  logic serial_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  remote_transmitter #(.CUSTOM_CODE(CUSTOM), .GAP_CYCLES(GAP_A), .CHECK_KEY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .send(send_a), .tecla(tecla_a),
    .serial(serial_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  remote_transmitter #(.CUSTOM_CODE(CUSTOM), .GAP_CYCLES(GAP_B), .CHECK_KEY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .send(send_b), .tecla(tecla_b),
    .serial(serial_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  // Expected {serial, busy, done, err} per cycle; an empty queue means idle.
  logic [3:0] sb_a[$];
  logic [3:0] sb_b[$];
  logic [7:0] rx_exp[$];
  logic [7:0] burst_keys[$];
  int rx_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit spec_valid(input logic [7:0] k);
    if (k > 8'h1F) return 1'b0;
    case (k)
      8'h0A, 8'h0B, 8'h0D, 8'h0E, 8'h15, 8'h19, 8'h1C, 8'h1D: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic push_exp(input bit to_b, input logic [3:0] v);
    if (to_b) sb_b.push_back(v);
    else sb_a.push_back(v);
  endtask

  // One frame starting at the next edge; first_done marks a START on a done cycle.
  task automatic push_frame(input bit to_b, input logic [7:0] key, input bit first_done);
    logic [32:0] bits;
    int gap;
    bits = {1'b1, CUSTOM, key, ~key};
    gap  = to_b ? GAP_B : GAP_A;
    push_exp(to_b, {1'b0, 1'b1, first_done, 1'b0});
    for (int i = 32; i >= 0; i--) push_exp(to_b, {bits[i], 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < gap; i++) push_exp(to_b, 4'b1100);
    if (!to_b) rx_exp.push_back(key);
  endtask

  task automatic drive(input bit to_b, input logic s, input logic [7:0] k);
    if (to_b) begin
      send_b  = s;
      tecla_b = k;
    end else begin
      send_a  = s;
      tecla_a = k;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 3000;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
  endtask

  // Back-to-back frames with send held high; next key set just before each done edge.
  task automatic burst(input bit to_b, input int n);
    int len;
    len = 34 + (to_b ? GAP_B : GAP_A);
    for (int i = 0; i < n; i++) begin
      drive(to_b, 1'b1, burst_keys[i]);
      push_frame(to_b, burst_keys[i], i != 0);
      if (i == n - 1) push_exp(to_b, 4'b1010);
      repeat (len) @(negedge clk);
    end
    drive(to_b, 1'b0, 8'h00);
  endtask

  // Line monitor, sampled 1 time unit after each rising edge.
  initial begin
    logic [3:0] exp_a, exp_b;
    forever begin
      @(posedge clk);
      #1;
      exp_a = 4'b1000;
      exp_b = 4'b1000;
      if (sb_a.size() != 0) exp_a = sb_a.pop_front();
      if (sb_b.size() != 0) exp_b = sb_b.pop_front();
      check("a_line", {serial_a, busy_a, done_a, err_a}, exp_a);
      check("b_line", {serial_b, busy_b, done_b, err_b}, exp_b);
    end
  end

  // Receiver stand-in: arms on a low bit, collects PAD + 32 bits, validates the frame.
  initial begin
    bit collecting;
    int nb;
    logic [32:0] sh;
    collecting = 1'b0;
    nb = 0;
    sh = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        collecting = 1'b0;
        nb = 0;
      end else if (!collecting) begin
        if (serial_a == 1'b0) begin
          collecting = 1'b1;
          nb = 0;
        end
      end else begin
        sh = {sh[31:0], serial_a};
        nb++;
        if (nb == 33) begin
          collecting = 1'b0;
          rx_count++;
          check("rx_pad", sh[32], 1'b1);
          check("rx_custom", sh[31:16], CUSTOM);
          check("rx_inv", sh[7:0], 8'(~sh[15:8]));
          check("rx_pending", rx_exp.size() != 0, 1'b1);
          if (rx_exp.size() != 0) check("rx_key", sh[15:8], rx_exp.pop_front());
        end
      end
    end
  end

  initial begin
    int rx_before;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, key 0x05
    drive(0, 1'b1, 8'h05);
    push_frame(0, 8'h05, 1'b0);
    push_exp(0, 4'b1010);
    @(negedge clk);
    drive(0, 1'b0, 8'h05);
    drain();

    // Refused key, then the same key on the unchecked instance
    drive(0, 1'b1, 8'h0A);
    push_exp(0, 4'b1001);
    @(negedge clk);
    drive(0, 1'b0, 8'h0A);
    repeat (40) @(negedge clk);
    drive(1, 1'b1, 8'h0A);
    push_frame(1, 8'h0A, 1'b0);
    push_exp(1, 4'b1010);
    @(negedge clk);
    drive(1, 1'b0, 8'h0A);
    drain();

    // send held, tecla wandering mid-frame; second frame starts on the done cycle
    drive(0, 1'b1, 8'h07);
    push_frame(0, 8'h07, 1'b0);
    push_frame(0, 8'h12, 1'b1);
    push_exp(0, 4'b1010);
    @(negedge clk);
    tecla_a = 8'h0A;
    repeat (20) @(negedge clk);
    tecla_a = 8'h1C;
    repeat (17) @(negedge clk);
    tecla_a = 8'h12;
    @(negedge clk);
    send_a = 1'b0;
    drain();

    // Asynchronous reset in the middle of DATA
    drive(0, 1'b1, 8'h11);
    push_frame(0, 8'h11, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h11);
    repeat (20) @(posedge clk);
    #2;
    check("pre_rst_serial", serial_a, 1'b0);
    rst = 1'b0;
    sb_a.delete();
    rx_exp.delete();
    #1;
    check("rst_serial", serial_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 8'h1F);
    push_frame(0, 8'h1F, 1'b0);
    push_exp(0, 4'b1010);
    @(negedge clk);
    drive(0, 1'b0, 8'h1F);
    drain();

    // Loopback: every valid key, back-to-back
    burst_keys.delete();
    for (int k = 0; k < 256; k++) if (spec_valid(8'(k))) burst_keys.push_back(8'(k));
    check("valid_key_count", burst_keys.size(), 24);
    rx_before = rx_count;
    burst(0, burst_keys.size());
    drain();
    check("rx_ready_count", rx_count - rx_before, 24);

    // Longer gap, two back-to-back frames on the unchecked instance
    burst_keys.delete();
    burst_keys.push_back(8'hC3);
    burst_keys.push_back(8'h3C);
    burst(1, 2);
    drain();

    check("rx_left", rx_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
